// File: rtl/peripheral_bus_arbiter.sv
// Round-robin arbiter serialising core accesses onto the shared peripheral RAM bus, with bus lock for atomic sequences.
// Optional lock timeout is enabled by defining ARB_LOCK_TIMEOUT_EN.
module peripheral_bus_arbiter #(
    parameter int NumberOfCores = 4,
    parameter int AddrWidth     = 16,
    parameter int DataWidth     = 8,
    parameter int RamLatency    = 1,
    parameter int LockTimeout   = 64
) (
    input  logic                                 CLK,
    input  logic                                 RESET_N,
    input  logic                                 ARB_EN,
    input  logic                                 ARB_Flush,
    input  logic [NumberOfCores-1:0]             REQ,
    input  logic [NumberOfCores-1:0]             LOCK,
    input  logic [NumberOfCores-1:0]             WE,
    input  logic [NumberOfCores*AddrWidth-1:0]   ADDR,
    input  logic [NumberOfCores*DataWidth-1:0]   WDATA,
    output logic [NumberOfCores-1:0]             GNT,
    output logic [NumberOfCores-1:0]             ACK,
    output logic [DataWidth-1:0]                 RDATA,
    output logic                                 RAM_WE,
    output logic [AddrWidth-1:0]                 RAM_ADDR,
    output logic [DataWidth-1:0]                 RAM_WDATA,
    input  logic [DataWidth-1:0]                 RAM_RDATA,
    output logic                                 BUSY,
    output logic                                 TIMEOUT_ERR,
    output logic [1:0]                           DBG_STATE
);

    localparam int IdxW = $clog2(NumberOfCores);
    localparam int LatW = 3;
    localparam logic [LatW-1:0] LastLat = LatW'(RamLatency - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    if ((NumberOfCores < 2) || (NumberOfCores > 8) || (RamLatency < 1) || (RamLatency > 4) ||
        (LockTimeout < 1)) begin : g_bad_param
        $error("peripheral_bus_arbiter: parameter out of range");
    end

    logic [1:0]      state;
    logic [IdxW-1:0] ptr;
    logic [IdxW-1:0] owner;
    logic            cur_we;
    logic [LatW-1:0] lat_cnt;

    logic [IdxW-1:0] pick;
    logic            pick_valid;
    logic [IdxW:0]   rr_sum;
    logic [IdxW-1:0] sel;
    logic            sel_we;
    logic [AddrWidth-1:0] sel_addr;
    logic [DataWidth-1:0] sel_wdata;

`ifdef ARB_LOCK_TIMEOUT_EN
    localparam int TmoW = $clog2(LockTimeout + 1);
    localparam logic [TmoW-1:0] LastTmo = TmoW'(LockTimeout - 1);
    logic [TmoW-1:0] tmo_cnt;
    logic            tmo_err;
    assign TIMEOUT_ERR = tmo_err;
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

    assign DBG_STATE = state;

    function automatic logic [NumberOfCores-1:0] onehot(input logic [IdxW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    function automatic logic [IdxW-1:0] next_ptr(input logic [IdxW-1:0] i);
        if (i == IdxW'(NumberOfCores - 1)) next_ptr = '0;
        else                               next_ptr = i + 1'b1;
    endfunction

    // Scan downwards so the last hit is the first requester at or after ptr.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        rr_sum     = '0;
        for (int k = NumberOfCores - 1; k >= 0; k--) begin
            rr_sum = {1'b0, ptr} + (IdxW + 1)'(k);
            if (rr_sum >= (IdxW + 1)'(NumberOfCores)) rr_sum = rr_sum - (IdxW + 1)'(NumberOfCores);
            if (REQ[rr_sum[IdxW-1:0]]) begin
                pick_valid = 1'b1;
                pick       = rr_sum[IdxW-1:0];
            end
        end
    end

    // A locked owner re-enters ACCESS without arbitration, so its own request is muxed.
    always_comb begin
        sel       = (state == S_HOLD) ? owner : pick;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NumberOfCores; k++) begin
            if (sel == IdxW'(k)) begin
                sel_we    = WE[k];
                sel_addr  = ADDR[k*AddrWidth +: AddrWidth];
                sel_wdata = WDATA[k*DataWidth +: DataWidth];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            ptr       <= '0;
            owner     <= '0;
            cur_we    <= 1'b0;
            lat_cnt   <= '0;
            GNT       <= '0;
            ACK       <= '0;
            RDATA     <= '0;
            RAM_WE    <= 1'b0;
            RAM_ADDR  <= '0;
            RAM_WDATA <= '0;
            BUSY      <= 1'b0;
`ifdef ARB_LOCK_TIMEOUT_EN
            tmo_cnt   <= '0;
            tmo_err   <= 1'b0;
`endif
        end else if (ARB_Flush) begin
            state   <= S_IDLE;
            ptr     <= '0;
            lat_cnt <= '0;
            GNT     <= '0;
            ACK     <= '0;
            RAM_WE  <= 1'b0;
            BUSY    <= 1'b0;
`ifdef ARB_LOCK_TIMEOUT_EN
            tmo_cnt <= '0;
            tmo_err <= 1'b0;
`endif
        end else begin
            ACK <= '0;
            case (state)
                S_IDLE: begin
                    if (ARB_EN && pick_valid) begin
                        owner     <= pick;
                        GNT       <= onehot(pick);
                        RAM_WE    <= sel_we;
                        cur_we    <= sel_we;
                        RAM_ADDR  <= sel_addr;
                        RAM_WDATA <= sel_wdata;
                        lat_cnt   <= '0;
                        BUSY      <= 1'b1;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    RAM_WE <= 1'b0;
                    if (lat_cnt == LastLat) begin
                        if (!cur_we) RDATA <= RAM_RDATA;
                        ACK   <= onehot(owner);
                        state <= S_DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (LOCK[owner]) begin
                        state <= S_HOLD;
`ifdef ARB_LOCK_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end else begin
                        GNT   <= '0;
                        ptr   <= next_ptr(owner);
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (REQ[owner]) begin
                        RAM_WE    <= sel_we;
                        cur_we    <= sel_we;
                        RAM_ADDR  <= sel_addr;
                        RAM_WDATA <= sel_wdata;
                        lat_cnt   <= '0;
                        state     <= S_ACCESS;
                    end else if (!LOCK[owner]) begin
                        GNT   <= '0;
                        ptr   <= next_ptr(owner);
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
`ifdef ARB_LOCK_TIMEOUT_EN
                    end else if (tmo_cnt == LastTmo) begin
                        GNT     <= '0;
                        ptr     <= next_ptr(owner);
                        BUSY    <= 1'b0;
                        tmo_err <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    gnt_onehot: assert property (@(posedge CLK) disable iff (!RESET_N) $onehot0(GNT));

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Self-checking bench for peripheral_bus_arbiter: table-driven single accesses plus
// round-robin, lock, enable/flush, lock-timeout (ARB_LOCK_TIMEOUT_EN aware) and async reset sequences.
module tb_peripheral_bus_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int L  = 1;
    localparam int LT = 8;

    logic              clk;
    logic              rst_n;
    logic              arb_en;
    logic              arb_flush;
    logic [N-1:0]      req;
    logic [N-1:0]      lock;
    logic [N-1:0]      we;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic [N-1:0]      gnt;
    logic [N-1:0]      ack;
    logic [DW-1:0]     rdata;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_wdata;
    logic [DW-1:0]     ram_rdata;
    logic              busy;
    logic              timeout_err;
    logic [1:0]        dbg_state;

    peripheral_bus_arbiter #(
        .NumberOfCores(N), .AddrWidth(AW), .DataWidth(DW), .RamLatency(L), .LockTimeout(LT)
    ) dut (
        .CLK(clk), .RESET_N(rst_n), .ARB_EN(arb_en), .ARB_Flush(arb_flush),
        .REQ(req), .LOCK(lock), .WE(we), .ADDR(addr), .WDATA(wdata),
        .GNT(gnt), .ACK(ack), .RDATA(rdata),
        .RAM_WE(ram_we), .RAM_ADDR(ram_addr), .RAM_WDATA(ram_wdata), .RAM_RDATA(ram_rdata),
        .BUSY(busy), .TIMEOUT_ERR(timeout_err), .DBG_STATE(dbg_state)
    );

    // Clock and RAM model (combinational read, write on the strobe edge)
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:255];
    assign ram_rdata = mem[ram_addr[7:0]];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[8'h10] <= 8'hA5;
            mem[8'h20] <= 8'h9E;
            mem[8'h44] <= 8'h77;
        end else if (ram_we) begin
            mem[ram_addr[7:0]] <= ram_wdata;
        end
    end

    int n_vec;
    int n_miss;
    logic [N+DW-1:0] exp_q[$];
    logic [N+DW-1:0] sb_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int c);
        oh    = '0;
        oh[c] = 1'b1;
    endfunction

    function automatic int gidx(input logic [N-1:0] g);
        gidx = -1;
        for (int i = 0; i < N; i++) if (g[i]) gidx = i;
    endfunction

    task automatic set_core(input int c, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[c]            = r;
        we[c]             = w;
        addr[c*AW +: AW]  = a;
        wdata[c*DW +: DW] = d;
    endtask

    // Scoreboard: every ACK pops the expected {ACK, RDATA} pair
    always @(negedge clk) begin
        if (rst_n && ack !== '0) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_ack: got ack=%b rdata=%h, expected no ack", ack, rdata);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_ack_rdata", {ack, rdata}, sb_exp);
            end
        end
    end

    task automatic wait_ack(input int c, input string name, output logic [N-1:0] first_g);
        bit done;
        done    = 1'b0;
        first_g = '0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (first_g == '0 && gnt != '0) first_g = gnt;
            if (ack[c]) begin
                done   = 1'b1;
                req[c] = 1'b0;
            end
        end
        check({name, "_ack_seen"}, done, 1);
    endtask

    typedef struct {
        int            core;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];
    vec_t v;

    // Single isolated access; called at posedge+1 with the arbiter in IDLE
    task automatic do_access(input vec_t t);
        int gc, ac;
        logic [N-1:0] g_seen;
        logic we_seen, we_at_ack;
        logic [AW-1:0] a_seen;
        logic [DW-1:0] d_seen;
        gc = 0; ac = 0; g_seen = '0; we_seen = 1'b0; we_at_ack = 1'b1; a_seen = '0; d_seen = '0;
        exp_q.push_back({oh(t.core), t.exp_rdata});
        set_core(t.core, 1'b1, t.we, t.addr, t.wdata);
        for (int cyc = 0; cyc < 12 && ac == 0; cyc++) begin
            @(negedge clk);
            if (gc == 0 && gnt != '0) begin
                gc = cyc; g_seen = gnt; we_seen = ram_we; a_seen = ram_addr; d_seen = ram_wdata;
            end
            if (ack != '0) begin
                ac = cyc; we_at_ack = ram_we;
            end
        end
        set_core(t.core, 1'b0, 1'b0, '0, '0);
        check("vec_gnt_cycle", gc, 1);
        check("vec_ack_cycle", ac, L + 1);
        check("vec_gnt", g_seen, oh(t.core));
        check("vec_ram_we", we_seen, t.we);
        check("vec_ram_addr", a_seen, t.addr);
        check("vec_ram_wdata", d_seen, t.wdata);
        check("vec_ram_we_dropped", we_at_ack, 0);
        @(posedge clk); #1;
    endtask

    int order[8];
    int ack_t[5];
    int exp_order[5];
    int ng, nack, we_cnt;
    logic [N-1:0] prev_g;
    int a1, a2, a3, g1, g2f, bad_gnt, we_seen3;
    logic [AW-1:0] we_addr3;
    logic [DW-1:0] we_data3;
    logic [N-1:0] fg;
    int hold_bad, en_bad;

    initial begin
        n_vec = 0; n_miss = 0;
        rst_n = 1'b0; arb_en = 1'b1; arb_flush = 1'b0;
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;

        vecs[0] = '{0, 1'b0, 16'h0010, 8'h00, 8'hA5};
        vecs[1] = '{1, 1'b1, 16'h0031, 8'h3C, 8'hA5};
        vecs[2] = '{2, 1'b0, 16'h0031, 8'h00, 8'h3C};
        vecs[3] = '{3, 1'b1, 16'h00F2, 8'h5A, 8'h3C};
        vecs[4] = '{3, 1'b0, 16'h00F2, 8'h00, 8'h5A};
        vecs[5] = '{0, 1'b0, 16'h0044, 8'h00, 8'h77};
        exp_order = '{0, 1, 2, 3, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {gnt, ack, ram_we, busy, timeout_err, dbg_state}, 0);
        check("reset_data", {rdata, ram_wdata, ram_addr}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) do_access(vecs[i]);

        // Round robin with all cores requesting continuously
        arb_flush = 1'b1;
        @(posedge clk); #1;
        arb_flush = 1'b0;
        exp_q.push_back({oh(0), 8'hA5});
        exp_q.push_back({oh(1), 8'hA5});
        exp_q.push_back({oh(2), 8'h77});
        exp_q.push_back({oh(3), 8'h77});
        exp_q.push_back({oh(0), 8'hA5});
        set_core(0, 1'b1, 1'b0, 16'h0010, 8'h00);
        set_core(1, 1'b1, 1'b1, 16'h0050, 8'h11);
        set_core(2, 1'b1, 1'b0, 16'h0044, 8'h00);
        set_core(3, 1'b1, 1'b1, 16'h0060, 8'h22);
        ng = 0; nack = 0; we_cnt = 0; prev_g = '0;
        for (int i = 0; i < 8; i++) order[i] = -1;
        for (int i = 0; i < 5; i++) ack_t[i] = 0;
        for (int cyc = 0; cyc < 40 && nack < 5; cyc++) begin
            @(negedge clk);
            if (gnt != '0 && prev_g == '0 && ng < 8) begin
                order[ng] = gidx(gnt);
                ng++;
            end
            if (ram_we) we_cnt++;
            if (ack != '0) begin
                ack_t[nack] = cyc;
                nack++;
                if (nack == 5) req = '0;
            end
            prev_g = gnt;
        end
        check("rr_ack_count", nack, 5);
        for (int i = 0; i < 5; i++) check($sformatf("rr_order_%0d", i), order[i], exp_order[i]);
        check("rr_first_ack", ack_t[0], L + 1);
        for (int i = 1; i < 5; i++) check($sformatf("rr_ack_spacing_%0d", i), ack_t[i] - ack_t[i-1], L + 2);
        check("rr_ram_we_pulses", we_cnt, 2);
        @(posedge clk); #1;

        // Lock: core2 read then write back-to-back while core1 waits
        exp_q.push_back({oh(2), 8'h9E});
        exp_q.push_back({oh(2), 8'h9E});
        exp_q.push_back({oh(1), 8'h77});
        set_core(2, 1'b1, 1'b0, 16'h0020, 8'h00);
        lock[2] = 1'b1;
        a1 = -1; a2 = -1; a3 = -1; g1 = -1; g2f = -1; bad_gnt = 0; we_seen3 = 0;
        we_addr3 = '0; we_data3 = '0;
        for (int cyc = 0; cyc < 60 && a3 < 0; cyc++) begin
            @(negedge clk);
            if (g2f < 0 && gnt == oh(2)) begin
                g2f = cyc;
                set_core(1, 1'b1, 1'b0, 16'h0044, 8'h00);
            end
            if (g2f >= 0 && a2 < 0 && gnt != oh(2)) bad_gnt++;
            if (ram_we) begin
                we_seen3++; we_addr3 = ram_addr; we_data3 = ram_wdata;
            end
            if (ack == oh(2)) begin
                if (a1 < 0) begin
                    a1 = cyc;
                    set_core(2, 1'b1, 1'b1, 16'h0020, 8'h01);
                end else begin
                    a2 = cyc;
                    set_core(2, 1'b0, 1'b0, '0, '0);
                    lock[2] = 1'b0;
                end
            end
            if (g1 < 0 && gnt == oh(1)) g1 = cyc;
            if (ack == oh(1)) begin
                a3 = cyc;
                set_core(1, 1'b0, 1'b0, '0, '0);
            end
        end
        check("lock_done", a3 >= 0, 1);
        check("lock_first_ack", a1, L + 1);
        check("lock_back_to_back", a2 - a1, L + 2);
        check("lock_gnt_held", bad_gnt, 0);
        check("lock_core1_after_release", g1, a2 + 2);
        check("lock_core1_ack", a3, g1 + L);
        check("lock_write_pulses", we_seen3, 1);
        check("lock_write_addr", we_addr3, 16'h0020);
        check("lock_write_data", we_data3, 8'h01);
        check("lock_mem_written", mem[8'h20], 8'h01);
        @(posedge clk); #1;

        // Enable: no grants while disabled, resume from current pointer
        arb_en = 1'b0;
        set_core(1, 1'b1, 1'b0, 16'h0044, 8'h00);
        en_bad = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (gnt != '0 || busy) en_bad++;
        end
        check("en_off_no_grant", en_bad, 0);
        set_core(0, 1'b1, 1'b0, 16'h0010, 8'h00);
        set_core(3, 1'b1, 1'b0, 16'h0060, 8'h00);
        exp_q.push_back({oh(3), 8'h22});
        arb_en = 1'b1;
        wait_ack(3, "en_resume", fg);
        req[0] = 1'b0; req[1] = 1'b0;
        check("en_resume_ptr", fg, oh(3));
        @(posedge clk); #1;

        // Flush mid-ACCESS aborts without ACK and resets the pointer
        v = '{1, 1'b0, 16'h0044, 8'h00, 8'h77};
        do_access(v);
        set_core(2, 1'b1, 1'b1, 16'h0070, 8'hEE);
        @(negedge clk);
        @(negedge clk);
        check("flush_pre_gnt", {gnt, ram_we}, {oh(2), 1'b1});
        arb_flush = 1'b1;
        set_core(2, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("flush_outputs", {ack, gnt, ram_we, busy, dbg_state}, 0);
        arb_flush = 1'b0;
        set_core(1, 1'b1, 1'b0, 16'h0044, 8'h00);
        set_core(3, 1'b1, 1'b0, 16'h0060, 8'h00);
        exp_q.push_back({oh(1), 8'h77});
        wait_ack(1, "flush_ptr", fg);
        req[3] = 1'b0;
        check("flush_ptr_zero", fg, oh(1));
        @(posedge clk); #1;

        // Lock held without requests
        exp_q.push_back({oh(3), 8'h22});
        set_core(3, 1'b1, 1'b0, 16'h0060, 8'h00);
        lock[3] = 1'b1;
        wait_ack(3, "tmo_first", fg);
        set_core(0, 1'b1, 1'b0, 16'h0010, 8'h00);
        exp_q.push_back({oh(0), 8'hA5});
        hold_bad = 0;
`ifdef ARB_LOCK_TIMEOUT_EN
        for (int k = 1; k <= LT; k++) begin
            @(negedge clk);
            if (gnt != oh(3) || timeout_err) hold_bad++;
        end
        check("tmo_hold_cycles", hold_bad, 0);
        @(negedge clk);
        check("tmo_release", {gnt, timeout_err}, {4'b0000, 1'b1});
        @(negedge clk);
        check("tmo_next_grant", gnt, oh(0));
        lock[3] = 1'b0;
        wait_ack(0, "tmo_core0", fg);
        @(posedge clk); #1;
        check("tmo_sticky", timeout_err, 1);
        arb_flush = 1'b1;
        @(posedge clk); #1;
        arb_flush = 1'b0;
        check("tmo_flush_clear", timeout_err, 0);
`else
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (gnt != oh(3) || timeout_err) hold_bad++;
        end
        check("hold_indefinite", hold_bad, 0);
        lock[3] = 1'b0;
        wait_ack(0, "hold_release", fg);
        check("hold_release_grant", fg, oh(0));
        @(posedge clk); #1;
`endif

        // Asynchronous reset in the middle of an access
        v = '{1, 1'b0, 16'h0044, 8'h00, 8'h77};
        do_access(v);
        set_core(2, 1'b1, 1'b0, 16'h0020, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("arst_pre_gnt", gnt, oh(2));
        #2 rst_n = 1'b0;
        #1;
        check("arst_ctrl", {gnt, ack, ram_we, busy, timeout_err, dbg_state}, 0);
        check("arst_data", {rdata, ram_wdata, ram_addr}, 0);
        set_core(2, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_core(0, 1'b1, 1'b0, 16'h0010, 8'h00);
        set_core(3, 1'b1, 1'b0, 16'h0060, 8'h00);
        exp_q.push_back({oh(0), 8'hA5});
        wait_ack(0, "arst_ptr", fg);
        req[3] = 1'b0;
        check("arst_ptr_zero", fg, oh(0));
        @(posedge clk); #1;

        repeat (3) @(negedge clk);
        check("sb_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
